// File: rtl/addsub_accum_unit.sv
// Registered add/subtract/accumulate unit with valid/ready handshake, signed accumulator,
// saturating sample counter and sticky overflow flag. Define ADDSUB_SAT_EN to clamp the accumulator on overflow.
module addsub_accum_unit #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             neg,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        MODE_SUB     = 2'b00,
        MODE_ADD     = 2'b01,
        MODE_ACC_SUB = 2'b10,
        MODE_ACC_CLR = 2'b11
    } mode_e;

    localparam int D_W = WIDTH + 2;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Two's-complement overflow: equal operand signs, differing sum sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Wrap by default; clamp by the sign of the true (ACC_W+1)-bit sum when saturation is built in.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] sum_in,
                                                        input logic ovf_now);
        logic signed [ACC_W-1:0] r;
        r = sum_in[ACC_W-1:0];
        if (SAT_EN && ovf_now) begin
            r = sum_in[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    logic                    out_valid_q;
    logic [ACC_W-1:0]        result_q, result_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic signed [D_W-1:0]   a_s, b_s, d_s;
    logic signed [ACC_W-1:0] d_ext;
    logic signed [ACC_W:0]   sum;
    logic                    sum_ovf;
    logic                    accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Operands are unsigned; two guard bits keep A+B and A-B exact before sign extension.
    assign a_s     = $signed({2'b00, op_a});
    assign b_s     = $signed({2'b00, op_b});
    assign d_s     = (mode_e'(mode) == MODE_ADD) ? (a_s + b_s) : (a_s - b_s);
    assign d_ext   = ACC_W'(d_s);
    assign sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(d_ext);
    assign sum_ovf = add_ovf(acc_q[ACC_W-1], d_ext[ACC_W-1], sum[ACC_W-1]);

    always_comb begin
        result_d = result_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        case (mode_e'(mode))
            MODE_SUB, MODE_ADD: begin
                result_d = d_ext;
            end
            MODE_ACC_SUB: begin
                acc_d    = sat_acc(sum, sum_ovf);
                ovf_d    = ovf_q | sum_ovf;
                count_d  = (&count_q) ? count_q : count_q + CNT_W'(1);
                result_d = acc_d;
            end
            MODE_ACC_CLR: begin
                acc_d    = '0;
                ovf_d    = 1'b0;
                count_d  = '0;
                result_d = '0;
            end
            default: ;
        endcase
    end

    // Result stage: a new beat overwrites the result only when the previous one is consumed or absent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign neg       = result_q[ACC_W-1];
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_addsub_accum_unit.sv
// Bench for addsub_accum_unit: directed vector table, handshake corner sequences,
// and randomized traffic scored against an integer-arithmetic model.
module tb_addsub_accum_unit;

    localparam int WIDTH = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             neg, ovf;
    logic [CNT_W-1:0] count;

    addsub_accum_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .neg(neg), .ovf(ovf), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain integers, range-checked against the signed ACC_W-bit range.
    int m_acc = 0;
    bit m_ovf = 0;
    int m_cnt = 0;

    function automatic int wrap_acc(input int x);
        int y;
        y = x & ((1 << ACC_W) - 1);
        return (y >= (1 << (ACC_W-1))) ? y - (1 << ACC_W) : y;
    endfunction

    task automatic model(input logic [1:0] m, input int a, input int b,
                         output int r, output bit o, output int c);
        int t;
        int hi, lo;
        hi = (1 << (ACC_W-1)) - 1;
        lo = -(1 << (ACC_W-1));
        r  = 0;
        case (m)
            2'd0: r = a - b;
            2'd1: r = a + b;
            2'd2: begin
                t = m_acc + (a - b);
                if (t > hi || t < lo) m_ovf = 1'b1;
`ifdef ADDSUB_SAT_EN
                m_acc = (t > hi) ? hi : ((t < lo) ? lo : t);
`else
                m_acc = wrap_acc(t);
`endif
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                r = m_acc;
            end
            default: begin
                m_acc = 0;
                m_ovf = 1'b0;
                m_cnt = 0;
                r     = 0;
            end
        endcase
        r = r & ((1 << ACC_W) - 1);
        o = m_ovf;
        c = m_cnt;
    endtask

    task automatic apply_beat(input logic [1:0] m, input int a, input int b);
        @(negedge clk);
        mode      = m;
        op_a      = WIDTH'(a);
        op_b      = WIDTH'(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0] m;
        int         a;
        int         b;
        int         res;
        bit         neg;
        bit         ovf;
        int         cnt;
    } vec_t;

    typedef struct {
        int res;
        bit ovf;
        int cnt;
    } exp_t;

    vec_t vt[17];
    exp_t q[$];

    initial begin
        int   r, c;
        bit   o;
        bit   acc_last;
        exp_t e;

        // Directed table: edge cases of the datapath plus the accumulate/overflow walk.
        vt[0]  = '{2'd0, 3, 9, 'hFA, 1'b1, 1'b0, 0};
        vt[1]  = '{2'd0, 9, 3, 'h06, 1'b0, 1'b0, 0};
        vt[2]  = '{2'd1, 15, 15, 'h1E, 1'b0, 1'b0, 0};
        vt[3]  = '{2'd0, 0, 15, 'hF1, 1'b1, 1'b0, 0};
        vt[4]  = '{2'd3, 0, 0, 'h00, 1'b0, 1'b0, 0};
        for (int i = 0; i < 8; i++) vt[5+i] = '{2'd2, 15, 0, 15*(i+1), 1'b0, 1'b0, i+1};
`ifdef ADDSUB_SAT_EN
        vt[13] = '{2'd2, 15, 0, 'h7F, 1'b0, 1'b1, 9};
`else
        vt[13] = '{2'd2, 15, 0, 'h87, 1'b1, 1'b1, 9};
`endif
        vt[14] = '{2'd1, 2, 1, 'h03, 1'b0, 1'b1, 9};
        vt[15] = '{2'd3, 0, 0, 'h00, 1'b0, 1'b0, 0};
        vt[16] = '{2'd2, 0, 15, 'hF1, 1'b1, 1'b0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 2'd0;
        op_a      = '0;
        op_b      = '0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            apply_beat(vt[i].m, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d_result", i), int'(result), vt[i].res);
            chk($sformatf("vec%0d_neg", i), int'(neg), int'(vt[i].neg));
            chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vt[i].ovf));
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].cnt);
        end

        // Backpressure: first result held, second beat waits, then drains exactly once.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", int'(out_valid), 0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'd0;
        op_a      = 4'd9;
        op_b      = 4'd3;
        @(posedge clk);
        #1;
        chk("bp_first_result", int'(result), 'h06);
        @(negedge clk);
        mode = 2'd1;
        op_a = 4'd1;
        op_b = 4'd2;
        #1;
        chk("bp_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("bp_hold_result", int'(result), 'h06);
        chk("bp_hold_valid", int'(out_valid), 1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("bp_second_result", int'(result), 'h03);
        chk("bp_second_valid", int'(out_valid), 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_no_duplicate", int'(out_valid), 0);

        // Count saturation
        apply_beat(2'd3, 0, 0);
        for (int i = 0; i < 17; i++) apply_beat(2'd2, 0, 0);
        chk("cnt_saturate", int'(count), 15);
        chk("cnt_sat_result", int'(result), 0);

        // Randomized traffic with random backpressure
        apply_beat(2'd3, 0, 0);
        model(2'd3, 0, 0, r, o, c);
        q.push_back('{r, o, c});
        acc_last = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!(in_valid && !acc_last)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                mode     = 2'($urandom);
                op_a     = WIDTH'($urandom);
                op_b     = WIDTH'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_result", int'(result), e.res);
                    chk("rnd_neg", int'(neg), (e.res >> (ACC_W-1)) & 1);
                    chk("rnd_ovf", int'(ovf), int'(e.ovf));
                    chk("rnd_count", int'(count), e.cnt);
                end
            end
            acc_last = in_valid && in_ready;
            if (acc_last) begin
                model(mode, int'(op_a), int'(op_b), r, o, c);
                q.push_back('{r, o, c});
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("drain_unexpected_result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("drain_result", int'(result), e.res);
            end
        end
        chk("drain_queue_empty", q.size(), 0);

        // Reset while a result is held under backpressure
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'd2;
        op_a      = 4'd15;
        op_b      = 4'd0;
        @(posedge clk);
        #1;
        chk("rst_hold_valid", int'(out_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_drop_valid", int'(out_valid), 0);
        chk("rst_drop_result", int'(result), 0);
        chk("rst_drop_neg", int'(neg), 0);
        chk("rst_drop_ovf", int'(ovf), 0);
        chk("rst_drop_count", int'(count), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        apply_beat(2'd2, 1, 0);
        chk("post_rst_acc", int'(result), 1);
        chk("post_rst_count", int'(count), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
